// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//   Fetch sequencer that owns the program counter. It issues instruction
//   memory reads over a req/ack handshake (at most one outstanding) and keeps
//   the fetched word in a one-entry buffer for decode. Redirect priority is
//   exception > jump > branch > sequential PC+4.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall                       decode cannot take instr this cycle
//   exc                         exception redirect, target EXC_VECTOR
//   jump, jump_target           jump redirect and byte target
//   branch_taken, branch_target taken-branch redirect and byte target
//   imem_req, imem_addr         read request / byte address to imem
//   imem_ack, imem_rdata        read completion and instruction word
//   instr, instr_pc             buffered instruction and its byte address
//   instr_valid                 buffer holds an unconsumed instruction
//   pc                          address of the next instruction to fetch
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        exc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {BOOT, IDLE, WAIT, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    logic        redirect, issue, load, consume;
    logic [31:0] target;

    assign redirect = exc | jump | branch_taken;
    // Word-align every redirect target so pc[1:0] can never become nonzero.
    assign target   = (exc  ? EXC_VECTOR  :
                       jump ? jump_target : branch_target) & ~32'h3;

    // A new fetch may start only when the buffer will be free at the end of
    // this cycle; a redirect suppresses it since pc is about to change.
    assign issue    = (state_q == IDLE) & ~redirect & (~instr_valid_q | ~stall);
    assign consume  = instr_valid_q & ~stall;
    // In WAIT an ack coincident with a redirect carries a stale word: drop it.
    assign load     = imem_ack & (issue | ((state_q == WAIT) & ~redirect));

    // Request is combinational so a zero-wait memory sustains one fetch per
    // cycle; state is BOOT during reset, so imem_req drops immediately.
    assign imem_req  = issue | (state_q == WAIT) | (state_q == DRAIN);
    assign imem_addr = (state_q == IDLE) ? pc_q : req_addr_q;

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            BOOT:  state_d = IDLE;
            IDLE: begin
                if (issue) begin
                    req_addr_d = pc_q;
                    if (!imem_ack) state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack)      state_d = IDLE;
                else if (redirect) state_d = DRAIN;
            end
            DRAIN: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = BOOT;
        endcase

        // In WAIT pc still equals req_addr (a redirect would have blocked the
        // load), so pc+4 is the correct sequential successor in both cases.
        if (redirect) begin
            pc_d          = target;
            instr_valid_d = 1'b0;
        end else if (load) begin
            instr_d       = imem_rdata;
            instr_pc_d    = imem_addr;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
        end else if (consume) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        exc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] pc;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_ctrl #(.RESET_PC(32'h0), .EXC_VECTOR(32'h180)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .exc(exc),
        .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .pc(pc)
    );

    always #5 clk = ~clk;

    // Memory model: programmable wait states, data is a fixed function of address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    int wait_n = 0;
    int cnt = 0;
    assign imem_ack   = imem_req && (cnt == wait_n);
    assign imem_rdata = memf(imem_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= 0;
        else if (imem_req && imem_ack) cnt <= 0;
        else if (imem_req)         cnt <= cnt + 1;
    end

    // Scoreboard: expected instr_pc of every instruction decode accepts.
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && instr_valid && !stall) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL consume_unexpected: got instr_pc=%h, none expected", instr_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (instr_pc !== e || instr !== memf(e)) begin
                    n_err++;
                    $display("FAIL consume: got pc=%h instr=%h, want pc=%h instr=%h",
                             instr_pc, instr, e, memf(e));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        mid();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_pc", pc, 32'h0);

        // Zero-wait streaming
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        tick(); rst_n = 1'b1;
        mid(); chk("boot_req", 32'(imem_req), 32'h0);
        tick(); mid(); chk("f0_req", 32'(imem_req), 32'h1); chk("f0_addr", imem_addr, 32'h0);
        tick(); mid(); chk("f1_addr", imem_addr, 32'h4);
        tick(); mid(); chk("f2_addr", imem_addr, 32'h8); chk("f2_ipc", instr_pc, 32'h4);

        // Buffer full, stall for 5 cycles
        tick(); stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("stall_req", 32'(imem_req), 32'h0);
            chk("stall_ipc", instr_pc, 32'h8);
            chk("stall_instr", instr, memf(32'h8));
            tick();
        end
        stall = 1'b0;
        mid(); chk("unstall_req", 32'(imem_req), 32'h1); chk("unstall_addr", imem_addr, 32'hC);

        // Jump to 0x4 into a 3-wait-state memory, branch during the wait
        tick(); jump = 1'b1; jump_target = 32'h4; wait_n = 3;
        mid(); chk("jmp_req", 32'(imem_req), 32'h0);
        tick(); jump = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin branch_taken = 1'b1; branch_target = 32'h100; end
            if (i == 3) branch_taken = 1'b0;
            mid();
            chk("ws_req", 32'(imem_req), 32'h1);
            chk("ws_addr", imem_addr, 32'h4);
            chk("ws_valid", 32'(instr_valid), 32'h0);
            tick();
        end
        wait_n = 0;
        exp_q.push_back(32'h100);
        mid();
        chk("br_addr", imem_addr, 32'h100);
        chk("br_pc", pc, 32'h100);
        chk("br_valid", 32'(instr_valid), 32'h0);

        // Exception, jump and branch in the same cycle
        tick(); exc = 1'b1; jump = 1'b1; jump_target = 32'h40;
        branch_taken = 1'b1; branch_target = 32'h80;
        mid(); chk("prio_req", 32'(imem_req), 32'h0);
        tick(); exc = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        exp_q.push_back(32'h180);
        mid();
        chk("prio_pc", pc, 32'h180);
        chk("prio_addr", imem_addr, 32'h180);
        chk("prio_valid", 32'(instr_valid), 32'h0);

        // PC wrap and target alignment
        tick(); jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        mid();
        tick(); jump = 1'b0;
        mid(); chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); mid(); chk("wrap_pc", pc, 32'h0); chk("wrap_addr0", imem_addr, 32'h0);
        tick(); jump = 1'b1; jump_target = 32'h1003;
        exp_q.push_back(32'h1000);
        mid();
        tick(); jump = 1'b0;
        mid(); chk("align_addr", imem_addr, 32'h1000); chk("align_pc", pc, 32'h1000);

        // Reset in the middle of a WAIT
        tick(); wait_n = 5;
        mid(); chk("w_req", 32'(imem_req), 32'h1); chk("w_addr", imem_addr, 32'h1004);
        tick();
        mid(); chk("w2_addr", imem_addr, 32'h1004);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req", 32'(imem_req), 32'h0);
        chk("mrst_valid", 32'(instr_valid), 32'h0);
        chk("mrst_pc", pc, 32'h0);
        tick(); rst_n = 1'b1; wait_n = 0;
        mid(); chk("rboot_req", 32'(imem_req), 32'h0); chk("rboot_pc", pc, 32'h0);
        tick(); mid(); chk("rf_req", 32'(imem_req), 32'h1); chk("rf_addr", imem_addr, 32'h0);
        tick(); stall = 1'b1;
        mid();
        chk("rf_valid", 32'(instr_valid), 32'h1);
        chk("rf_ipc", instr_pc, 32'h0);
        chk("rf_instr", instr, memf(32'h0));
        chk("rf_hold_req", 32'(imem_req), 32'h0);

        tick(); mid();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
